// File: rtl/bram_stream_ctrl_if.sv
// Stream-side bundle of bram_stream_ctrl: the fill (s_*) input stream and the
// drain (m_*) output stream, both valid/ready. The controller takes the slave
// modport; whatever feeds and drains it takes the master modport.
interface bram_stream_ctrl_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  s_valid;
    logic                  s_ready;
    logic [DATA_WIDTH-1:0] s_data;
    logic                  s_last;
    logic                  m_valid;
    logic                  m_ready;
    logic [DATA_WIDTH-1:0] m_data;
    logic                  m_last;

    modport master (
        output s_valid, s_data, s_last, m_ready,
        input  s_ready, m_valid, m_data, m_last
    );

    modport slave (
        input  s_valid, s_data, s_last, m_ready,
        output s_ready, m_valid, m_data, m_last
    );
endinterface

// File: rtl/bram_stream_ctrl.sv
// Owns the single port of a 1-cycle-latency BRAM. FILL writes an input stream to
// addresses 0.. upward; DRAIN reads the filled region back through a 2-entry
// skid FIFO so the output stream tolerates arbitrary backpressure without
// losing or repeating a beat.
module bram_stream_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  fill_start,
    input  logic                  drain_start,
    bram_stream_ctrl_if.slave     strm,
    output logic                  fill_done,
    output logic                  drain_done,
    output logic                  busy,
    output logic [ADDR_WIDTH:0]   fill_count,
    output logic                  bram_write_enable,
    output logic                  bram_read_enable,
    output logic [ADDR_WIDTH-1:0] bram_address,
    output logic [DATA_WIDTH-1:0] bram_data_in,
    input  logic [DATA_WIDTH-1:0] bram_data_out
);
    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] CNT_ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH:0] LAST_IDX = (ADDR_WIDTH + 1)'(DEPTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH:0]   wr_cnt_q, wr_cnt_d;
    logic [ADDR_WIDTH:0]   rd_addr_q, rd_addr_d;
    logic [ADDR_WIDTH:0]   fill_count_q, fill_count_d;
    logic                  fill_done_q, fill_done_d;
    logic                  drain_done_q, drain_done_d;
    // FIFO entry 0 is always the head; a pop shifts entry 1 down.
    logic [1:0]            fifo_cnt_q, fifo_cnt_d;
    logic [DATA_WIDTH-1:0] fifo_data0_q, fifo_data0_d;
    logic [DATA_WIDTH-1:0] fifo_data1_q, fifo_data1_d;
    logic                  fifo_last0_q, fifo_last0_d;
    logic                  fifo_last1_q, fifo_last1_d;
    // A read issued last cycle whose data is on bram_data_out now.
    logic                  rd_pend_q, rd_pend_d;
    logic                  rd_pend_last_q, rd_pend_last_d;

    logic                  accept_s;
    logic                  pop_s;
    logic                  issue_s;
    logic [2:0]            occ_s;

    // State and datapath registers with synchronous reset; BRAM contents are not ours to clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            wr_cnt_q       <= '0;
            rd_addr_q      <= '0;
            fill_count_q   <= '0;
            fill_done_q    <= 1'b0;
            drain_done_q   <= 1'b0;
            fifo_cnt_q     <= 2'd0;
            fifo_data0_q   <= '0;
            fifo_data1_q   <= '0;
            fifo_last0_q   <= 1'b0;
            fifo_last1_q   <= 1'b0;
            rd_pend_q      <= 1'b0;
            rd_pend_last_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            wr_cnt_q       <= wr_cnt_d;
            rd_addr_q      <= rd_addr_d;
            fill_count_q   <= fill_count_d;
            fill_done_q    <= fill_done_d;
            drain_done_q   <= drain_done_d;
            fifo_cnt_q     <= fifo_cnt_d;
            fifo_data0_q   <= fifo_data0_d;
            fifo_data1_q   <= fifo_data1_d;
            fifo_last0_q   <= fifo_last0_d;
            fifo_last1_q   <= fifo_last1_d;
            rd_pend_q      <= rd_pend_d;
            rd_pend_last_q <= rd_pend_last_d;
        end
    end

    // Next-state logic: handshakes, read throttling, FIFO push/pop and FSM transitions.
    always_comb begin
        state_d        = state_q;
        wr_cnt_d       = wr_cnt_q;
        rd_addr_d      = rd_addr_q;
        fill_count_d   = fill_count_q;
        fill_done_d    = 1'b0;
        drain_done_d   = 1'b0;
        fifo_cnt_d     = fifo_cnt_q;
        fifo_data0_d   = fifo_data0_q;
        fifo_data1_d   = fifo_data1_q;
        fifo_last0_d   = fifo_last0_q;
        fifo_last1_d   = fifo_last1_q;

        accept_s = (state_q == ST_FILL) && strm.s_valid;
        pop_s    = (fifo_cnt_q != 2'd0) && strm.m_ready;
        // Buffered + in-flight words after this cycle's pop; a new read must still fit in 2.
        occ_s    = {1'b0, fifo_cnt_q} + {2'b00, rd_pend_q} - {2'b00, pop_s};
        issue_s  = (state_q == ST_DRAIN) && (rd_addr_q < fill_count_q) && (occ_s < 3'd2);

        rd_pend_d      = issue_s;
        rd_pend_last_d = issue_s && (rd_addr_q == (fill_count_q - CNT_ONE));
        if (issue_s) begin
            rd_addr_d = rd_addr_q + CNT_ONE;
        end else begin
            rd_addr_d = rd_addr_q;
        end

        if (pop_s) begin
            fifo_data0_d = fifo_data1_q;
            fifo_last0_d = fifo_last1_q;
            fifo_cnt_d   = fifo_cnt_q - 2'd1;
        end else begin
            fifo_cnt_d   = fifo_cnt_q;
        end

        if (rd_pend_q) begin
            if (fifo_cnt_d == 2'd0) begin
                fifo_data0_d = bram_data_out;
                fifo_last0_d = rd_pend_last_q;
            end else begin
                fifo_data1_d = bram_data_out;
                fifo_last1_d = rd_pend_last_q;
            end
            fifo_cnt_d = fifo_cnt_d + 2'd1;
        end else begin
            fifo_cnt_d = fifo_cnt_d;
        end

        case (state_q)
            ST_IDLE: begin
                if (fill_start) begin
                    state_d  = ST_FILL;
                    wr_cnt_d = '0;
                end else if (drain_start) begin
                    state_d   = ST_DRAIN;
                    rd_addr_d = '0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_FILL: begin
                if (accept_s) begin
                    wr_cnt_d = wr_cnt_q + CNT_ONE;
                    if (strm.s_last || (wr_cnt_q == LAST_IDX)) begin
                        fill_count_d = wr_cnt_q + CNT_ONE;
                        fill_done_d  = 1'b1;
                        state_d      = ST_IDLE;
                    end else begin
                        state_d = ST_FILL;
                    end
                end else begin
                    state_d = ST_FILL;
                end
            end
            ST_DRAIN: begin
                if (fill_count_q == '0) begin
                    drain_done_d = 1'b1;
                    state_d      = ST_IDLE;
                end else if (pop_s && fifo_last0_q) begin
                    drain_done_d = 1'b1;
                    state_d      = ST_IDLE;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign strm.s_ready      = (state_q == ST_FILL);
    assign strm.m_valid      = (fifo_cnt_q != 2'd0);
    assign strm.m_data       = fifo_data0_q;
    assign strm.m_last       = (fifo_cnt_q != 2'd0) && fifo_last0_q;

    assign bram_write_enable = accept_s;
    assign bram_read_enable  = issue_s;
    assign bram_address      = accept_s ? wr_cnt_q[ADDR_WIDTH-1:0]
                             : (issue_s ? rd_addr_q[ADDR_WIDTH-1:0] : {ADDR_WIDTH{1'b0}});
    assign bram_data_in      = accept_s ? strm.s_data : {DATA_WIDTH{1'b0}};

    assign fill_done         = fill_done_q;
    assign drain_done        = drain_done_q;
    assign busy              = (state_q != ST_IDLE);
    assign fill_count        = fill_count_q;
endmodule

// File: tb/tb_bram_stream_ctrl.sv
// Testbench for bram_stream_ctrl: BRAM behavioural model, reference memory image,
// expected-beat scoreboard with an independent output monitor.
module tb_bram_stream_ctrl;
    localparam int DW    = 8;
    localparam int AW    = 4;
    localparam int DEPTH = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic fill_start = 1'b0;
    logic drain_start = 1'b0;
    logic fill_done, drain_done, busy;
    logic [AW:0]   fill_count;
    logic          we, re;
    logic [AW-1:0] addr;
    logic [DW-1:0] din;
    logic [DW-1:0] bram_dout;

    bram_stream_ctrl_if #(.DATA_WIDTH(DW)) bus ();

    bram_stream_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk               (clk),
        .rst               (rst),
        .fill_start        (fill_start),
        .drain_start       (drain_start),
        .strm              (bus),
        .fill_done         (fill_done),
        .drain_done        (drain_done),
        .busy              (busy),
        .fill_count        (fill_count),
        .bram_write_enable (we),
        .bram_read_enable  (re),
        .bram_address      (addr),
        .bram_data_in      (din),
        .bram_data_out     (bram_dout)
    );

    always #5 clk = ~clk;

    // Single-port BRAM with registered read.
    logic [DW-1:0] mem [DEPTH];
    always @(posedge clk) begin
        if (we) mem[addr] <= din;
        if (re) bram_dout <= mem[addr];
    end

    // Reference: what the fill stream asked to be stored, and how many words.
    logic [DW-1:0] ref_mem [DEPTH];
    int            ref_fc = 0;
    logic [DW:0]   exp_q [$];
    int            pops = 0;
    int            errors = 0;
    int            checks = 0;

    task automatic chk(input bit ok, input string name, input longint act, input longint req);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: BRAM port rules, outstanding reads, stall stability, beat scoreboard.
    initial begin
        int issued = 0;
        int popped = 0;
        bit stall_prev = 1'b0;
        logic [DW:0] stall_beat = '0;
        logic [DW:0] exp_b;
        forever begin
            @(negedge clk);
            if (rst) begin
                exp_q.delete();
                issued = 0;
                popped = 0;
                stall_prev = 1'b0;
            end else begin
                chk(!(we && re) && (we || re || addr == '0) && (!re || int'(addr) < ref_fc),
                    "bram_port", {we, re, addr}, ref_fc);
                if (stall_prev)
                    chk(bus.m_valid && ({bus.m_last, bus.m_data} == stall_beat),
                        "stall_hold", {bus.m_valid, bus.m_last, bus.m_data}, {1'b1, stall_beat});
                if (re) issued++;
                if (bus.m_valid && bus.m_ready) begin
                    popped++;
                    pops++;
                    if (exp_q.size() == 0) begin
                        chk(1'b0, "extra_beat", {bus.m_last, bus.m_data}, 0);
                    end else begin
                        exp_b = exp_q.pop_front();
                        chk({bus.m_last, bus.m_data} == exp_b, "beat", {bus.m_last, bus.m_data}, exp_b);
                    end
                end
                chk(issued - popped <= 2, "outstanding", issued - popped, 2);
                stall_prev = bus.m_valid && !bus.m_ready;
                stall_beat = {bus.m_last, bus.m_data};
            end
        end
    end

    // Fill: beat i carries seq ? base+i : random; s_last on beat n-1 when use_last.
    task automatic do_fill(input int n, input bit use_last, input int gap_pct, input bit alt,
                           input bit seq, input logic [DW-1:0] base, input bit both_starts);
        logic [DW-1:0] d;
        int cnt = 0;
        bit end_s = 1'b0;
        fill_start  = 1'b1;
        drain_start = both_starts;
        tick();
        fill_start  = 1'b0;
        drain_start = 1'b0;
        for (int i = 0; i < DEPTH && !end_s; i++) begin
            if (i > 0 && (alt || $urandom_range(0, 99) < gap_pct)) begin
                bus.s_valid = 1'b0;
                tick();
            end
            d = seq ? base + DW'(i) : DW'($urandom);
            bus.s_valid = 1'b1;
            bus.s_data  = d;
            bus.s_last  = use_last && (i == n - 1);
            @(negedge clk);
            if (i == 0) chk(busy && bus.s_ready, "fill_entry", {busy, bus.s_ready}, 2'b11);
            chk(we && addr == AW'(i) && din == d, "fill_write", {we, addr, din}, {1'b1, AW'(i), d});
            ref_mem[i] = d;
            end_s = bus.s_last || (i == DEPTH - 1);
            cnt = i + 1;
            tick();
        end
        ref_fc = cnt;
        // Offer one more beat: it must not be accepted.
        bus.s_last  = 1'b0;
        bus.s_valid = 1'b1;
        bus.s_data  = 8'hEE;
        @(negedge clk);
        chk(fill_done && fill_count == 5'(ref_fc) && !busy && !bus.s_ready && !we, "fill_end",
            {fill_done, busy, bus.s_ready, we, fill_count}, {4'b1000, 5'(ref_fc)});
        bus.s_valid = 1'b0;
        tick();
        @(negedge clk);
        chk(!fill_done, "fill_done_pulse", fill_done, 0);
    endtask

    function automatic logic ready_for(input int mode, input int edges);
        if (mode == 0) return 1'b1;
        if (mode == 1) return $urandom_range(0, 3) != 0;
        if (edges < 4) return 1'b1;
        if (edges < 11) return 1'b0;
        return (edges % 2) == 1;
    endfunction

    // Drain: expected beats queued up front; mode 0 ready=1, 1 random, 2 stall-then-toggle.
    task automatic do_drain(input int mode);
        int edges = 0;
        bit done = 1'b0;
        for (int k = 0; k < ref_fc; k++)
            exp_q.push_back({(k == ref_fc - 1), ref_mem[k]});
        bus.m_ready = ready_for(mode, 0);
        drain_start = 1'b1;
        tick();
        drain_start = 1'b0;
        while (!done && edges < 400) begin
            @(negedge clk);
            if (mode == 0 && ref_fc > 0 && edges == 1) chk(!bus.m_valid, "lat_e1", bus.m_valid, 0);
            if (mode == 0 && ref_fc > 0 && edges == 2) chk(bus.m_valid, "lat_e2", bus.m_valid, 1);
            if (drain_done) begin
                done = 1'b1;
            end else begin
                tick();
                edges++;
                bus.m_ready = ready_for(mode, edges);
            end
        end
        chk(done, "drain_done_seen", done, 1);
        if (mode == 0) chk(edges == (ref_fc == 0 ? 1 : ref_fc + 2), "drain_cycles", edges, ref_fc == 0 ? 1 : ref_fc + 2);
        chk(exp_q.size() == 0 && !busy && !bus.m_valid, "drain_complete", {exp_q.size(), busy, bus.m_valid}, 0);
        bus.m_ready = 1'b0;
        tick();
        @(negedge clk);
        chk(!drain_done, "drain_done_pulse", drain_done, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base, w;
        bus.s_valid = 1'b0;
        bus.s_data  = '0;
        bus.s_last  = 1'b0;
        bus.m_ready = 1'b0;

        // Reset, then idle with every output low.
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        repeat (10) begin
            @(negedge clk);
            chk({bus.s_ready, bus.m_valid, bus.m_last, bus.m_data, fill_done, drain_done, busy,
                 fill_count, we, re, addr, din} == '0, "reset_idle",
                {bus.s_ready, bus.m_valid, bus.m_last, bus.m_data, fill_done, drain_done, busy,
                 fill_count, we, re, addr, din}, 0);
            tick();
        end

        // Full fill, full-rate drain, stalled drain, replay.
        do_fill(16, 1'b0, 0, 1'b0, 1'b1, 8'h01, 1'b0);
        do_drain(0);
        do_drain(2);

        // Short fill with s_last and gapped s_valid.
        do_fill(5, 1'b1, 0, 1'b1, 1'b1, 8'hA0, 1'b0);
        do_drain(0);

        // Randomized fills and drains.
        repeat (6) begin
            int n = $urandom_range(1, 16);
            do_fill(n, (n < 16) ? 1'b1 : 1'(($urandom % 2)), $urandom_range(0, 60), 1'b0, 1'b0, 8'h00, 1'b0);
            do_drain($urandom_range(0, 1));
            if ($urandom_range(0, 1) == 1) do_drain(1);
        end

        // Reset in the middle of a drain.
        do_fill(16, 1'b0, 0, 1'b0, 1'b1, 8'h30, 1'b0);
        for (int k = 0; k < ref_fc; k++)
            exp_q.push_back({(k == ref_fc - 1), ref_mem[k]});
        bus.m_ready = 1'b1;
        drain_start = 1'b1;
        tick();
        drain_start = 1'b0;
        base = pops;
        w = 0;
        while (pops - base < 3 && w < 50) begin
            tick();
            w++;
        end
        chk(pops - base == 3, "abort_point", pops - base, 3);
        rst = 1'b1;
        ref_fc = 0;
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk(!bus.m_valid && !busy && fill_count == '0 && !drain_done, "abort_reset",
            {bus.m_valid, busy, drain_done, fill_count}, 0);
        tick();
        @(negedge clk);
        chk(!drain_done && !busy, "abort_no_done", {drain_done, busy}, 0);
        bus.m_ready = 1'b1;
        do_drain(0);

        // Simultaneous starts: fill wins.
        do_fill(3, 1'b1, 0, 1'b0, 1'b0, 8'h00, 1'b1);
        do_drain(1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/bram_stream_ctrl.md
Name: bram_stream_ctrl

Overview:
Hardware controller that owns the single port of a BRAM instance (DATA_WIDTH x 2^ADDR_WIDTH, registered read, 1-cycle latency).
- Fill: accepts a valid/ready input stream and writes it into consecutive addresses from 0.
- Drain: reads the filled region back and emits it as a valid/ready output stream with full backpressure support.
- Replaces bench-driven load/readback of BRAM contents inside the datapath.

Parameters:
DATA_WIDTH, 8, width of a BRAM word and of both stream data buses
ADDR_WIDTH, 4, BRAM address width
DEPTH, 1<<ADDR_WIDTH, number of BRAM words (derived; not overridden)

Ports:
clk  in  1  system clock; everything on rising edge
rst  in  1  synchronous, active-high reset
fill_start  in  1  request fill; honoured only in IDLE
drain_start  in  1  request drain; honoured only in IDLE
s_valid  in  1  input beat valid
s_ready  out  1  input beat accepted when s_valid&&s_ready
s_data  in  DATA_WIDTH  input beat data
s_last  in  1  final input beat of fill
m_valid  out  1  output beat valid
m_ready  in  1  downstream accepts beat
m_data  out  DATA_WIDTH  output beat data
m_last  out  1  final output beat of drain
fill_done  out  1  one-cycle pulse, fill complete
drain_done  out  1  one-cycle pulse, drain complete
busy  out  1  state != IDLE
fill_count  out  ADDR_WIDTH+1  words written by last completed fill (0..DEPTH)
bram_write_enable  out  1  to BRAM write_enable
bram_read_enable  out  1  to BRAM read_enable
bram_address  out  ADDR_WIDTH  to BRAM address
bram_data_in  out  DATA_WIDTH  to BRAM data_in
bram_data_out  in  DATA_WIDTH  from BRAM data_out; valid the cycle after the edge that samples read_enable

Behaviour:
- Reset:
  - state=IDLE; all outputs 0, including fill_count, s_ready, m_valid, m_last, pulses and BRAM controls.
  - Output FIFO and in-flight tracking cleared.
  - BRAM contents untouched.
  - Reset mid-fill or mid-drain aborts immediately, with no done pulse.
- States: IDLE, FILL, DRAIN.
- IDLE:
  - fill_start -> FILL, wr_addr=0.
  - Otherwise drain_start -> DRAIN, rd_addr=0.
  - Simultaneous starts: fill wins and drain_start is dropped.
  - Starts outside IDLE are ignored.
- FILL:
  - s_ready=1 (combinational from state).
  - On accept: bram_write_enable=1, bram_address=wr_addr, bram_data_in=s_data (combinational, same cycle); wr_addr increments at the edge.
  - Fill ends on an accepted beat with s_last=1, or on the DEPTH-th accepted beat, whichever comes first.
  - At that edge: fill_count <= beats written (1..DEPTH), state -> IDLE, fill_done pulses high for the following cycle.
  - No wrap-around; beat DEPTH+1 is never accepted.
- DRAIN:
  - Internal 2-entry output FIFO; head drives m_valid/m_data/m_last.
  - Read issue condition: rd_addr<fill_count and (FIFO occupancy + reads in flight - pop this cycle) < 2.
  - On issue: bram_read_enable=1, bram_address=rd_addr (combinational); rd_addr increments.
  - The read returns the next cycle and is pushed into the FIFO at the following edge.
  - The entry for address fill_count-1 carries last=1.
  - Latency: drain_start sampled at edge E0; address 0 read at E1; m_valid high after E2.
  - With m_ready held 1: one beat per cycle, no bubbles.
  - While m_valid&&!m_ready, m_data and m_last hold stable; no beat is lost or duplicated.
  - Pop of the m_last beat -> state IDLE; drain_done pulses the next cycle.
  - drain_start with fill_count=0: enter DRAIN, issue no reads, return to IDLE at the next edge, pulse drain_done, never assert m_valid.
- bram_write_enable and bram_read_enable are never high together.
- bram_address=0 when neither enable is high.
- fill_count persists across drains; repeated drains replay the same data.

Test Plan:
1. Hold rst 2 cycles, then release with no starts -> all outputs 0, busy=0, no BRAM enables for 10 cycles.
2. fill_start, then 16 beats 0x01..0x10 with s_valid=1 continuously and s_last=0 -> writes to addr 0..15 on 16 consecutive cycles; fill_done one cycle; fill_count=16; s_ready=0 afterwards.
3. drain_start, m_ready=1 -> m_valid first high 2 edges after E0; m_data 0x01..0x10 on 16 consecutive cycles; m_last only with 0x10; drain_done one cycle later.
4. Drain with m_ready=0 for beats 3-7, then toggling every cycle -> m_data frozen during stalls; exactly 0x01..0x10 delivered once each in order; never more than 2 reads outstanding.
5. Fill 0xA0..0xA4 with s_last on 0xA4 and s_valid gapped every other cycle -> fill_count=5; drain yields 0xA0..0xA4, m_last on 0xA4; addr 5 never read.
6. Assert rst after 3 drain beats -> next cycle m_valid=0, busy=0, fill_count=0, no drain_done. drain_start -> drain_done pulse, zero beats. Simultaneous fill_start+drain_start -> FILL entered.
